mux4_sel_reg: RTL and testbench

//  - Registered 4:1 word multiplexer for the datapath operand-select stage.
//  - Selects one of four WIDTH-bit operands (A, B, C, D) by 2-bit sel and registers the result.
//  - The D leg is pre-shifted left by one, with a 0 inserted at the LSB.
//  - Feeds ALU/register-file write paths; one cycle of latency, valid-qualified.

---
 rtl/mux4_pkg.sv | 11 +
 rtl/mux4_sel_comb.sv | 32 +++
 rtl/mux4_sel_reg.sv | 69 ++++++
 tb/tb_mux4_sel_reg.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mux4_pkg.sv
// Shared constants for the registered 4:1 operand-select mux.
package mux4_pkg;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;
  localparam logic [1:0] SEL_D = 2'd3;

  localparam int unsigned D_SHIFT = 1;

endpackage

// File: rtl/mux4_sel_comb.sv
// Combinational operand selector; the D leg is shifted left by D_SHIFT with zero fill.
module mux4_sel_comb
  import mux4_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] sel_result_c
);

  logic [WIDTH-1:0] w_d_shifted;

  // MSB of D falls off the top; no carry-out is kept.
  assign w_d_shifted = D << D_SHIFT;

  // Only the addressed leg reaches the output, so X on other legs stays contained.
  always_comb begin
    sel_result_c = '0;
    unique case (sel)
      SEL_A: sel_result_c = A;
      SEL_B: sel_result_c = B;
      SEL_C: sel_result_c = C;
      SEL_D: sel_result_c = w_d_shifted;
      default: sel_result_c = '0;
    endcase
  end

endmodule

// File: rtl/mux4_sel_reg.sv
// Registered 4:1 operand-select stage with one cycle of valid-qualified latency.
// Optional even-parity output O_par is built when MUX4_PARITY_EN is defined.
module mux4_sel_reg
  import mux4_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  input  logic [1:0]       sel,
  input  logic             in_valid,
  output logic [WIDTH-1:0] O,
  output logic             out_valid
`ifdef MUX4_PARITY_EN
  ,
  output logic             O_par
`endif
);

  logic [WIDTH-1:0] w_sel_result;
  logic [WIDTH-1:0] r_o;
  logic             r_out_valid;

  mux4_sel_comb #(
    .WIDTH (WIDTH)
  ) u_sel (
    .A            (A),
    .B            (B),
    .C            (C),
    .D            (D),
    .sel          (sel),
    .sel_result_c (w_sel_result)
  );

  // Data holds when idle; valid is a single-cycle pulse per capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_o         <= '0;
      r_out_valid <= 1'b0;
    end else if (in_valid) begin
      r_o         <= w_sel_result;
      r_out_valid <= 1'b1;
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign O         = r_o;
  assign out_valid = r_out_valid;

`ifdef MUX4_PARITY_EN
  logic r_o_par;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_o_par <= 1'b0;
    end else if (in_valid) begin
      r_o_par <= ^w_sel_result;
    end
  end

  assign O_par = r_o_par;
`endif

endmodule

// File: tb/tb_mux4_sel_reg.sv
// Self-checking bench for mux4_sel_reg: spec-level model checked every cycle plus literal vectors.
module tb_mux4_sel_reg;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a, b, c, d;
  logic [1:0]   sel;
  logic         in_valid;
  logic [W-1:0] o;
  logic         out_valid;
`ifdef MUX4_PARITY_EN
  logic         o_par;
`endif

  int total = 0;
  int bad   = 0;

  logic [W-1:0] m_o;
  logic         m_v;

  always #5 clk = ~clk;

  mux4_sel_reg #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (a),
    .B         (b),
    .C         (c),
    .D         (d),
    .sel       (sel),
    .in_valid  (in_valid),
    .O         (o),
    .out_valid (out_valid)
`ifdef MUX4_PARITY_EN
    ,
    .O_par     (o_par)
`endif
  );

  // Spec-level selection: operand by index, D doubled modulo 2^W.
  function automatic logic [W-1:0] pick(input logic [W-1:0] pa, pb, pc, pd,
                                        input logic [1:0] s);
    logic [W:0] dbl;
    dbl = {1'b0, pd} * (W+1)'(2);
    case (s)
      2'd0:    return pa;
      2'd1:    return pb;
      2'd2:    return pc;
      default: return dbl[W-1:0];
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst_n === 1'b0) begin
      m_o = '0;
      m_v = 1'b0;
    end else if (in_valid === 1'b1) begin
      m_o = pick(a, b, c, d, sel);
      m_v = 1'b1;
    end else begin
      m_v = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous compare against the model on every falling edge.
  always @(negedge clk) begin
    chk("model_O", o, m_o);
    chk("model_valid", W'(out_valid), W'(m_v));
`ifdef MUX4_PARITY_EN
    chk("model_par", W'(o_par), W'(^m_o));
`endif
  end

  task automatic step(input logic r, input logic v, input logic [1:0] s);
    rst_n    = r;
    in_valid = v;
    sel      = s;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [W-1:0] sweep_exp [4];

  initial begin
    sweep_exp = '{32'd3, 32'd5, 32'd7, 32'd22};
    a = 32'd3; b = 32'd5; c = 32'd7; d = 32'd11;
    rst_n = 1'b0; in_valid = 1'b1; sel = 2'd1;

    // reset held two cycles with in_valid asserted
    step(1'b0, 1'b1, 2'd1);
    step(1'b0, 1'b1, 2'd2);
    chk("rst_O", o, 32'd0);
    chk("rst_valid", W'(out_valid), 32'd0);
`ifdef MUX4_PARITY_EN
    chk("rst_par", W'(o_par), 32'd0);
`endif

    // sweep all four legs back to back
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 2'(i));
      chk("sweep_O", o, sweep_exp[i]);
      chk("sweep_valid", W'(out_valid), 32'd1);
    end

    // hold: sel moves while idle, O must not
    step(1'b1, 1'b1, 2'd1);
    chk("hold_cap_O", o, 32'd5);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 2'd2);
      chk("hold_O", o, 32'd5);
      chk("hold_valid", W'(out_valid), 32'd0);
    end

    // shift edge: MSB of D is dropped
    d = 32'h8000_0001;
    step(1'b1, 1'b1, 2'd3);
    chk("shift_O", o, 32'h0000_0002);

    // reset mid-stream overrides in_valid
    d = 32'd11;
    step(1'b1, 1'b1, 2'd2);
    chk("mid_cap_O", o, 32'd7);
    step(1'b0, 1'b1, 2'd2);
    chk("mid_rst_O", o, 32'd0);
    chk("mid_rst_valid", W'(out_valid), 32'd0);

    // parity vectors (first capture after reset)
    step(1'b1, 1'b1, 2'd0);
    chk("par_a_O", o, 32'd3);
`ifdef MUX4_PARITY_EN
    chk("par_a", W'(o_par), 32'd0);
`endif
    b = 32'd7;
    step(1'b1, 1'b1, 2'd1);
    chk("par_b_O", o, 32'd7);
`ifdef MUX4_PARITY_EN
    chk("par_b", W'(o_par), 32'd1);
`endif

    // X on unselected operands must stay out of O
    a = 32'hDEAD_BEEF; b = 'x; c = 'x; d = 'x;
    step(1'b1, 1'b1, 2'd0);
    chk("xblock_O", o, 32'hDEAD_BEEF);

    // all-ones corners
    a = 32'hFFFF_FFFF; b = 32'd0; c = 32'h1234_5678; d = 32'hFFFF_FFFF;
    step(1'b1, 1'b1, 2'd3);
    chk("ones_d_O", o, 32'hFFFF_FFFE);
    step(1'b1, 1'b1, 2'd2);
    chk("c_O", o, 32'h1234_5678);
    step(1'b1, 1'b1, 2'd1);
    chk("zero_b_O", o, 32'd0);
    step(1'b1, 1'b0, 2'd0);
    chk("idle_O", o, 32'd0);
    chk("idle_valid", W'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
